// File: rtl/hilo_pkg.sv
// Shared types and sizing for the HI/LO divide sequencer.
// Optional feature macro used by this slice: HILO_DIVZERO_FLAG_EN.
package hilo_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CLR  = 3'd1,
    RUN  = 3'd2,
    OUT  = 3'd3,
    WB   = 3'd4
  } state_t;

  localparam int DIV_ITERS_DEF = 33;

  function automatic int iter_w(input int iters);
    return (iters < 2) ? 1 : $clog2(iters + 1);
  endfunction

  localparam int ITER_W = iter_w(DIV_ITERS_DEF);

endpackage

// File: rtl/hilo_div_ctrl_if.sv
// Pipeline-side bus of the HI/LO divide sequencer (EX stage is master).
interface hilo_div_ctrl_if #(
  parameter int WIDTH = 32
);
  // DIVU handshake: a transfer happens at a posedge where req_valid & req_ready;
  // dividend/divisor must be stable while req_valid is high. req_valid may be
  // raised regardless of req_ready, and once raised should be held until accepted.
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             mthi_we;
  logic             mtlo_we;
  logic [WIDTH-1:0] mt_data;
  logic             mf_rd;
  logic             mf_sel;
  logic [WIDTH-1:0] mf_data;
  logic             stall;
  logic             done;

  modport master (
    output req_valid, dividend, divisor, mthi_we, mtlo_we, mt_data, mf_rd, mf_sel,
    input  req_ready, mf_data, stall, done
  );

  modport slave (
    input  req_valid, dividend, divisor, mthi_we, mtlo_we, mt_data, mf_rd, mf_sel,
    output req_ready, mf_data, stall, done
  );

endinterface

// File: rtl/hilo_div_core.sv
// Iterative restoring unsigned divider: first div_signal cycle loads operands, then one
// quotient bit per cycle; result {REM,QUOT} latched on any div_signal=0 cycle. No self-clear.
module hilo_div_core #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               div_reset,
  input  logic               div_signal,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic [2*WIDTH-1:0] div_out
);

  localparam int CW = $clog2(WIDTH + 2);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [WIDTH:0]   trial;

  always_comb begin
    trial = {acc, q[WIDTH-1]} - {1'b0, d};
  end

  always_ff @(posedge clk) begin
    if (div_reset) begin
      cnt <= '0;
      acc <= '0;
      q   <= '0;
    end else if (div_signal) begin
      if (cnt == '0) begin
        q   <= dividend;
        d   <= divisor;
        acc <= '0;
        cnt <= CW'(1);
      end else if (cnt <= CW'(WIDTH)) begin
        if (!trial[WIDTH]) begin
          acc <= trial[WIDTH-1:0];
          q   <= {q[WIDTH-2:0], 1'b1};
        end else begin
          acc <= {acc[WIDTH-2:0], q[WIDTH-1]};
          q   <= {q[WIDTH-2:0], 1'b0};
        end
        cnt <= cnt + CW'(1);
      end
    end else begin
      div_out <= {acc, q};
    end
  end

endmodule

// File: rtl/hilo_regs.sv
// HI/LO architectural registers: divide write-back beats MTHI/MTLO, plus MFHI/MFLO read mux.
module hilo_regs #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wb_we,
  input  logic [WIDTH-1:0] wb_hi,
  input  logic [WIDTH-1:0] wb_lo,
  input  logic             mthi_we,
  input  logic             mtlo_we,
  input  logic [WIDTH-1:0] mt_data,
  input  logic             mf_sel,
  output logic [WIDTH-1:0] mf_data
);

  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi <= '0;
      lo <= '0;
    end else if (wb_we) begin
      hi <= wb_hi;
      lo <= wb_lo;
    end else begin
      if (mthi_we) hi <= mt_data;
      if (mtlo_we) lo <= mt_data;
    end
  end

  assign mf_data = mf_sel ? hi : lo;

endmodule

// File: rtl/hilo_div_ctrl.sv
// DIVU sequencer between EX and an external iterative divider; owns HI/LO and the pipeline stall.
// Optional HILO_DIVZERO_FLAG_EN: zero divisor bypasses the divider and raises div_zero in WB.
module hilo_div_ctrl
  import hilo_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DIV_ITERS = DIV_ITERS_DEF
) (
  input  logic               clk,
  input  logic               reset,
  hilo_div_ctrl_if.slave     bus,
  output logic               div_reset,
  output logic               div_signal,
  output logic [WIDTH-1:0]   div_dividend,
  output logic [WIDTH-1:0]   div_divisor,
  input  logic [2*WIDTH-1:0] div_out,
`ifdef HILO_DIVZERO_FLAG_EN
  output logic               div_zero,
`endif
  output state_t             dbg_state
);

  localparam int IW = iter_w(DIV_ITERS);
  localparam logic [IW-1:0] ITER_LAST = IW'(DIV_ITERS - 1);

  state_t          state;
  logic [IW-1:0]   iter;
  logic            done_q;
  logic            idle;
  logic            busy;
  logic            transfer;
  logic [WIDTH-1:0] wb_hi;
  logic [WIDTH-1:0] wb_lo;

  assign idle     = (state == IDLE);
  assign busy     = !idle;
  assign transfer = bus.req_valid & idle;

  assign bus.req_ready = idle;
  assign bus.stall     = busy & (bus.req_valid | bus.mf_rd | bus.mthi_we | bus.mtlo_we);
  assign bus.done      = done_q;
  assign dbg_state     = state;

`ifdef HILO_DIVZERO_FLAG_EN
  logic zero_q;
  assign div_zero = zero_q;
  assign wb_hi    = zero_q ? div_dividend : div_out[2*WIDTH-1:WIDTH];
  assign wb_lo    = zero_q ? {WIDTH{1'b1}} : div_out[WIDTH-1:0];
`else
  assign wb_hi    = div_out[2*WIDTH-1:WIDTH];
  assign wb_lo    = div_out[WIDTH-1:0];
`endif

  // Outputs are registered, so each is set on the edge entering the state that owns it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      iter         <= '0;
      div_dividend <= '0;
      div_divisor  <= '0;
      done_q       <= 1'b0;
      div_reset    <= 1'b0;
      div_signal   <= 1'b0;
`ifdef HILO_DIVZERO_FLAG_EN
      zero_q       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (transfer) begin
            div_dividend <= bus.dividend;
            div_divisor  <= bus.divisor;
`ifdef HILO_DIVZERO_FLAG_EN
            if (bus.divisor == '0) begin
              state  <= WB;
              done_q <= 1'b1;
              zero_q <= 1'b1;
            end else begin
              state     <= CLR;
              div_reset <= 1'b1;
            end
`else
            state     <= CLR;
            div_reset <= 1'b1;
`endif
          end
        end
        CLR: begin
          div_reset  <= 1'b0;
          div_signal <= 1'b1;
          iter       <= '0;
          state      <= RUN;
        end
        RUN: begin
          iter <= iter + IW'(1);
          if (iter == ITER_LAST) begin
            div_signal <= 1'b0;
            state      <= OUT;
          end
        end
        OUT: begin
          done_q <= 1'b1;
          state  <= WB;
        end
        WB: begin
          done_q <= 1'b0;
`ifdef HILO_DIVZERO_FLAG_EN
          zero_q <= 1'b0;
`endif
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  hilo_regs #(.WIDTH(WIDTH)) u_regs (
    .clk     (clk),
    .reset   (reset),
    .wb_we   (state == WB),
    .wb_hi   (wb_hi),
    .wb_lo   (wb_lo),
    .mthi_we (bus.mthi_we & idle),
    .mtlo_we (bus.mtlo_we & idle),
    .mt_data (bus.mt_data),
    .mf_sel  (bus.mf_sel),
    .mf_data (bus.mf_data)
  );

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Directed bench for hilo_div_ctrl paired with hilo_div_core: DIVU table plus reset,
// MT/DIVU overlap and zero-divisor sequences.
module tb_hilo_div_ctrl;
  import hilo_pkg::*;

  localparam int W = 32;

  // clock / reset
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  hilo_div_ctrl_if #(.WIDTH(W)) bus ();

  logic           div_reset;
  logic           div_signal;
  logic [W-1:0]   div_dividend;
  logic [W-1:0]   div_divisor;
  logic [2*W-1:0] div_out;
  state_t         dbg_state;
`ifdef HILO_DIVZERO_FLAG_EN
  logic           div_zero;
`endif

  hilo_div_ctrl #(.WIDTH(W), .DIV_ITERS(33)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus.slave),
    .div_reset    (div_reset),
    .div_signal   (div_signal),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_out      (div_out),
`ifdef HILO_DIVZERO_FLAG_EN
    .div_zero     (div_zero),
`endif
    .dbg_state    (dbg_state)
  );

  hilo_div_core #(.WIDTH(W)) u_core (
    .clk        (clk),
    .div_reset  (div_reset),
    .div_signal (div_signal),
    .dividend   (div_dividend),
    .divisor    (div_divisor),
    .div_out    (div_out)
  );

  // scoreboard
  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic idle_inputs();
    bus.req_valid = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.mthi_we   = 1'b0;
    bus.mtlo_we   = 1'b0;
    bus.mt_data   = '0;
    bus.mf_rd     = 1'b0;
    bus.mf_sel    = 1'b0;
  endtask

  task automatic read_hilo(output logic [W-1:0] hi, output logic [W-1:0] lo);
    bus.mf_sel = 1'b1;
    #1 hi = bus.mf_data;
    bus.mf_sel = 1'b0;
    #1 lo = bus.mf_data;
  endtask

  // Issues one DIVU and checks the handshake, stall, WB pulse and final HI/LO
  // against the next two entries of exp_q (HI then LO).
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    logic [W-1:0] old_hi, old_lo, hi, lo, ehi, elo;
    int lat;
    lat = 36;
`ifdef HILO_DIVZERO_FLAG_EN
    if (b == '0) lat = 1;
`endif
    @(negedge clk);
    read_hilo(old_hi, old_lo);
    check({tag, " req_ready idle"}, W'(bus.req_ready), 1);
    bus.req_valid = 1'b1;
    bus.dividend  = a;
    bus.divisor   = b;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.mf_rd     = 1'b1;
    if (lat > 1) begin
      check({tag, " stall busy"}, W'(bus.stall), 1);
      check({tag, " req_ready busy"}, W'(bus.req_ready), 0);
    end
    repeat (lat - 1) @(posedge clk);
    #1;
    check({tag, " state WB"}, W'(dbg_state), W'(WB));
    check({tag, " done pulse"}, W'(bus.done), 1);
`ifdef HILO_DIVZERO_FLAG_EN
    check({tag, " div_zero"}, W'(div_zero), (b == '0) ? 1 : 0);
`endif
    read_hilo(hi, lo);
    check({tag, " HI before WB"}, hi, old_hi);
    bus.mf_rd = 1'b0;
    @(posedge clk);
    #1;
    ehi = exp_q.pop_front();
    elo = exp_q.pop_front();
    check({tag, " done cleared"}, W'(bus.done), 0);
    check({tag, " back in IDLE"}, W'(dbg_state), W'(IDLE));
    read_hilo(hi, lo);
    check({tag, " HI"}, hi, ehi);
    check({tag, " LO"}, lo, elo);
  endtask

  initial begin
    logic [W-1:0] hi, lo;

    vecs[0] = '{a: 32'd100,        b: 32'd7,  hi: 32'd2,  lo: 32'd14};
    vecs[1] = '{a: 32'hFFFF_FFFF,  b: 32'd16, hi: 32'd15, lo: 32'h0FFF_FFFF};
    vecs[2] = '{a: 32'd9,          b: 32'd3,  hi: 32'd0,  lo: 32'd3};
    vecs[3] = '{a: 32'd5,          b: 32'd0,  hi: 32'd5,  lo: 32'hFFFF_FFFF};

    // reset state
    idle_inputs();
    #12;
    check("reset state", W'(dbg_state), W'(IDLE));
    check("reset done", W'(bus.done), 0);
    check("reset div_reset", W'(div_reset), 0);
    check("reset div_signal", W'(div_signal), 0);
    read_hilo(hi, lo);
    check("reset HI", hi, 0);
    check("reset LO", lo, 0);
    @(negedge clk);
    reset = 1'b1;

    // MTHI and MTLO together write both registers
    @(negedge clk);
    bus.mthi_we = 1'b1;
    bus.mtlo_we = 1'b1;
    bus.mt_data = 32'h1111_1111;
    @(posedge clk);
    #1;
    bus.mthi_we = 1'b0;
    bus.mtlo_we = 1'b0;
    read_hilo(hi, lo);
    check("mt both HI", hi, 32'h1111_1111);
    check("mt both LO", lo, 32'h1111_1111);

    // reset asserted mid-RUN at iteration 10
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.dividend  = 32'd1000;
    bus.divisor   = 32'd3;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    check("mid-run state RUN", W'(dbg_state), W'(RUN));
    reset = 1'b0;
    #1;
    check("abort state", W'(dbg_state), W'(IDLE));
    check("abort req_ready", W'(bus.req_ready), 1);
    check("abort div_signal", W'(div_signal), 0);
    read_hilo(hi, lo);
    check("abort HI", hi, 0);
    check("abort LO", lo, 0);
    @(negedge clk);
    reset = 1'b1;
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd3);
    run_div(32'd7, 32'd2, "after abort 7/2");

    // table: back-to-back DIVUs including zero divisor
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(vecs[i].hi);
      exp_q.push_back(vecs[i].lo);
      run_div(vecs[i].a, vecs[i].b, $sformatf("vec%0d", i));
    end

    // MTHI in the same cycle as DIVU 20/6, MTLO while busy
    @(negedge clk);
    bus.mthi_we   = 1'b1;
    bus.mt_data   = 32'hA5A5_A5A5;
    bus.req_valid = 1'b1;
    bus.dividend  = 32'd20;
    bus.divisor   = 32'd6;
    @(posedge clk);
    #1;
    bus.mthi_we   = 1'b0;
    bus.req_valid = 1'b0;
    read_hilo(hi, lo);
    check("mthi with divu HI", hi, 32'hA5A5_A5A5);
    bus.mtlo_we = 1'b1;
    bus.mt_data = 32'h1234_5678;
    #1;
    check("mtlo busy stall", W'(bus.stall), 1);
    repeat (35) @(posedge clk);
    #1;
    check("overlap state WB", W'(dbg_state), W'(WB));
    read_hilo(hi, lo);
    check("mtlo busy ignored", lo, 32'hFFFF_FFFF);
    bus.mtlo_we = 1'b0;
    @(posedge clk);
    #1;
    read_hilo(hi, lo);
    check("overlap HI", hi, 32'd2);
    check("overlap LO", lo, 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
